t_ff: RTL and testbench
=======================

T_FF -- requirements
Module: t_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent toggle bits; the T and Q widths.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into Q on reset.
REQ-003 clk  input  1  sole clock; all state changes occur on its rising edge, except reset.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 T  input  WIDTH  toggle enable per bit; 1 = invert that Q bit at the next rising clk edge.
REQ-006 Q  output  WIDTH  registered flip-flop state.
REQ-007 Port declaration order SHALL be T, clk, rst, Q so positional instantiation t_ff(T, clk, rst, Q) binds correctly.
REQ-008 The design SHALL have one clock and an asynchronous, active-high reset; clock port clk, reset port rst.

Function
REQ-009 On a rising edge of rst, or whenever rst is high, Q SHALL take RST_VAL immediately, without waiting for a clk edge.
REQ-010 While rst is high, clk edges and T SHALL have no effect; Q SHALL stay at RST_VAL.
REQ-011 On each rising clk edge with rst low, each bit Q[i] SHALL become ~Q[i] if T[i]=1, else keep its value.
REQ-012 Latency: a change on T SHALL affect Q only at the first rising clk edge after the change; Q SHALL NOT respond combinationally to T.
REQ-013 Q SHALL be driven directly from the state register, with no combinational path from any input to Q other than the asynchronous reset.
REQ-014 State updates SHALL use non-blocking assignment semantics, so Q sampled by downstream logic at the same edge is the pre-edge value.
REQ-015 With T held at 1, Q SHALL alternate every clock cycle, giving a clk/2 square wave per bit.
REQ-016 With T held at 0, Q SHALL hold indefinitely.
REQ-017 Bits SHALL be fully independent; toggling one bit SHALL NOT affect any other.
REQ-018 If rst deasserts in the same timestep as a rising clk edge, that edge SHALL NOT toggle Q; the first toggle occurs at the next edge.
REQ-019 If rst asserts mid-cycle, Q SHALL return to RST_VAL at once, discarding any pending toggle.
REQ-020 Before the first reset, Q MAY be unknown; the design SHALL require a reset to reach a defined state.

Reset
REQ-021 The reset value of Q SHALL be RST_VAL (0 for the default configuration).
REQ-022 Reset SHALL be asynchronous on assertion; deassertion takes effect for the next clk edge.
REQ-023 No other internal state SHALL exist besides Q.

Verification
REQ-024 Clock period 10 ns, clk=0 at t=0; rst=1, T=0 for 0–10 ns -> Q=0 from the first rst assertion, including across the 5 ns edge.
REQ-025 rst=0 at 10 ns, T=0 through 30 ns -> Q stays 0 at the 15 ns and 25 ns edges.
REQ-026 T=1 at 30 ns -> Q=1 after the 35 ns edge; with T held, Q=0 at 45 ns and 1 at 55 ns (alternates each edge).
REQ-027 Q=1 and T=1, assert rst mid-cycle (e.g. 58 ns) -> Q=0 immediately, before the next edge; it stays 0 while rst is high.
REQ-028 Release rst coincident with a rising clk edge while T=1 -> no toggle at that edge; Q goes 0->1 at the following edge.
REQ-029 WIDTH=4, RST_VAL=4'b1010, T=4'b0011 after reset -> Q sequence 1010, 1001, 1010 on successive edges.

Source files
------------

// File: rtl/t_ff.sv
// Bank of WIDTH independent toggle flip-flops with an asynchronous active-high reset.
// Each Q bit inverts on a rising clk edge when its T bit is set.
module t_ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] T,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;

    // Next state: XOR with T flips exactly the enabled bits and keeps the rest.
    always_comb begin
        q_next_s = q_r;
        q_next_s = q_r ^ T;
    end

    // State register; reset wins over any clock edge seen while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff: a default 1-bit instance and a 4-bit instance with a
// non-zero reset value, checked through an expected-value queue.
module tb_t_ff;

    logic       clk;
    logic       rst;
    logic       t1;
    logic       q1;
    logic [3:0] t4;
    logic [3:0] q4;

    int n_cmp;
    int n_err;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];

    t_ff dut1 (
        .T   (t1),
        .clk (clk),
        .rst (rst),
        .Q   (q1)
    );

    t_ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1010)
    ) dut4 (
        .T   (t4),
        .clk (clk),
        .rst (rst),
        .Q   (q4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: observed no end of test, required end before 5000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [3:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard: observed %b with no expected value queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %b expected %b at %0t", e.tag, obs, e.val, $time);
            end
        end
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset from t=0 with T low, including across the 5 ns edge.
        rst = 1'b1;
        t1  = 1'b0;
        t4  = 4'b0000;
        push("rst_q1_t1", 4'b0000);
        push("rst_q4_t1", 4'b1010);
        wait_until(1);
        cmp({3'b000, q1});
        cmp(q4);
        push("rst_q1_t7", 4'b0000);
        wait_until(7);
        cmp({3'b000, q1});

        // Released, T low: hold at 15 and 25 ns edges.
        wait_until(10);
        rst = 1'b0;
        push("hold_q1_t17", 4'b0000);
        wait_until(17);
        cmp({3'b000, q1});
        push("hold_q1_t27", 4'b0000);
        push("hold_q4_t27", 4'b1010);
        wait_until(27);
        cmp({3'b000, q1});
        cmp(q4);

        // T high: no combinational response, then alternate each edge.
        wait_until(30);
        t1 = 1'b1;
        t4 = 4'b0011;
        push("no_comb_q1", 4'b0000);
        push("no_comb_q4", 4'b1010);
        wait_until(33);
        cmp({3'b000, q1});
        cmp(q4);
        push("tog_q1_t37", 4'b0001);
        push("tog_q4_t37", 4'b1001);
        wait_until(37);
        cmp({3'b000, q1});
        cmp(q4);
        push("tog_q1_t47", 4'b0000);
        wait_until(47);
        cmp({3'b000, q1});
        push("tog_q1_t57", 4'b0001);
        push("tog_q4_t57", 4'b1001);
        wait_until(57);
        cmp({3'b000, q1});
        cmp(q4);

        // Mid-cycle reset: immediate return to reset value, held across an edge.
        wait_until(58);
        rst = 1'b1;
        push("async_q1_t59", 4'b0000);
        push("async_q4_t59", 4'b1010);
        wait_until(59);
        cmp({3'b000, q1});
        cmp(q4);
        push("rst_hold_q1_t67", 4'b0000);
        push("rst_hold_q4_t67", 4'b1010);
        wait_until(67);
        cmp({3'b000, q1});
        cmp(q4);

        // Release coincident with the 75 ns edge: that edge must not toggle.
        @(posedge clk);
        rst <= 1'b0;
        push("rel_edge_q1_t77", 4'b0000);
        push("rel_edge_q4_t77", 4'b1010);
        wait_until(77);
        cmp({3'b000, q1});
        cmp(q4);
        push("first_tog_q1_t87", 4'b0001);
        push("first_tog_q4_t87", 4'b1001);
        wait_until(87);
        cmp({3'b000, q1});
        cmp(q4);

        // T low holds q1; single-bit toggle on q4 leaves other bits alone.
        wait_until(88);
        t1 = 1'b0;
        push("seq_q4_t97", 4'b1010);
        push("hold_q1_t97", 4'b0001);
        wait_until(97);
        cmp(q4);
        cmp({3'b000, q1});
        wait_until(98);
        t4 = 4'b0100;
        push("bit2_q4_t107", 4'b1110);
        push("hold_q1_t107", 4'b0001);
        wait_until(107);
        cmp(q4);
        cmp({3'b000, q1});
        push("bit2_q4_t117", 4'b1010);
        wait_until(117);
        cmp(q4);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
